chnl_responder: RTL and testbench



---
 rtl/chnl_pkg.sv | 8 +
 rtl/chnl_responder_if.sv | 21 ++
 rtl/chnl_fifo.sv | 41 ++++
 rtl/chnl_responder.sv | 51 +++++
 tb/tb_chnl_responder.sv | 114 +++++++++++
 5 files changed

// File: rtl/chnl_pkg.sv
// chnl_pkg: shared constants and types for the channel responder
package chnl_pkg;
  localparam int CHNL_DW = 32;
  localparam int CHNL_DEPTH = 32;
  localparam int CHNL_MW = 6;
  typedef logic [CHNL_DW-1:0] chnl_data_t;
  typedef logic [CHNL_MW-1:0] chnl_margin_t;
endpackage

// File: rtl/chnl_responder_if.sv
// chnl_responder_if: channel write side and arbiter pop side of the responder
interface chnl_responder_if;
  import chnl_pkg::*;
  chnl_data_t   ch_data_i;
  logic         ch_valid_i;
  logic         ch_ready_o;
  chnl_margin_t ch_margin_o;
  logic         en_i;
  chnl_data_t   a_data_o;
  logic         a_req_o;
  logic         a_ack_i;
  logic [15:0]  acc_cnt_o;
  modport slave (
    input  ch_data_i, ch_valid_i, en_i, a_ack_i,
    output ch_ready_o, ch_margin_o, a_data_o, a_req_o, acc_cnt_o
  );
  modport master (
    output ch_data_i, ch_valid_i, en_i, a_ack_i,
    input  ch_ready_o, ch_margin_o, a_data_o, a_req_o, acc_cnt_o
  );
endinterface

// File: rtl/chnl_fifo.sv
// chnl_fifo: synchronous FIFO with first-word-fall-through output
module chnl_fifo
  import chnl_pkg::*;
#(
  parameter int DW    = CHNL_DW,
  parameter int DEPTH = CHNL_DEPTH,
  parameter int MW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [MW-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [MW-1:0] r_count;
  always_ff @(posedge clk_i)
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + MW'(i_push) - MW'(i_pop);
    end
  assign o_full  = r_count == MW'(DEPTH);
  assign o_empty = r_count == '0;
  // empty head reads as zero so a stale entry never leaks to the arbiter
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/chnl_responder.sv
// chnl_responder: receiving end of the valid/ready channel; buffers words for the arbiter
module chnl_responder
  import chnl_pkg::*;
(
  input logic             clk_i,
  input logic             rstn_i,
  chnl_responder_if.slave ch
);
  logic         r_init;
  chnl_margin_t r_margin;
  logic [15:0]  r_acc_cnt;
  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  chnl_margin_t w_count;
  chnl_data_t   w_dout;
  assign ch.ch_ready_o  = r_init && ch.en_i && !w_full;
  assign w_push         = ch.ch_valid_i && ch.ch_ready_o;
  assign w_pop          = ch.a_ack_i && !w_empty;
  assign ch.a_req_o     = !w_empty;
  assign ch.a_data_o    = w_dout;
  assign ch.ch_margin_o = r_margin;
  assign ch.acc_cnt_o   = r_acc_cnt;
  chnl_fifo #(
    .DW    (CHNL_DW),
    .DEPTH (CHNL_DEPTH),
    .MW    (CHNL_MW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (ch.ch_data_i),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  // margin is held in its own register so it moves on the same edge as the FIFO count
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_init    <= 1'b0;
      r_margin  <= CHNL_MW'(CHNL_DEPTH);
      r_acc_cnt <= '0;
    end else begin
      r_init   <= 1'b1;
      r_margin <= CHNL_MW'(CHNL_DEPTH) - (w_count + CHNL_MW'(w_push) - CHNL_MW'(w_pop));
      if (w_push) r_acc_cnt <= r_acc_cnt + 16'd1;
    end
endmodule

// File: tb/tb_chnl_responder.sv
// tb_chnl_responder: directed and random stimulus against a queue-based reference model
module tb_chnl_responder;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  logic rstn_i;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q[$];
  bit m_init;
  logic [15:0] m_acc;
  chnl_responder_if ch();
  chnl_responder dut (
    .clk_i  (clk),
    .rstn_i (rstn_i),
    .ch     (ch)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("ready", 32'(ch.ch_ready_o), 32'(m_init && ch.en_i && q.size() != DEPTH));
    chk("req", 32'(ch.a_req_o), 32'(q.size() != 0));
    chk("data", ch.a_data_o, q.size() != 0 ? q[0] : 32'h0);
    chk("margin", 32'(ch.ch_margin_o), 32'(DEPTH - q.size()));
    chk("acc_cnt", 32'(ch.acc_cnt_o), 32'(m_acc));
  endtask
  // called just after a falling edge; applies inputs for one full clock cycle
  task automatic step(input logic v, input logic [31:0] d, input logic e, input logic k);
    bit rdy;
    ch.ch_valid_i = v;
    ch.ch_data_i  = d;
    ch.en_i       = e;
    ch.a_ack_i    = k;
    #1;
    rdy = m_init && e && q.size() != DEPTH;
    chk("ready_comb", 32'(ch.ch_ready_o), 32'(rdy));
    @(posedge clk);
    if (k && q.size() != 0) void'(q.pop_front());
    if (v && rdy) begin
      q.push_back(d);
      m_acc++;
    end
    m_init = 1'b1;
    @(negedge clk);
    check_all();
  endtask
  task automatic pulse_reset();
    #2 rstn_i = 1'b0;
    q.delete();
    m_init = 1'b0;
    m_acc = '0;
    #1;
    check_all();
    chk("rst_margin", 32'(ch.ch_margin_o), 32'd32);
    chk("rst_acc", 32'(ch.acc_cnt_o), 32'd0);
    @(negedge clk);
    rstn_i = 1'b1;
  endtask
  initial begin
    int pv, pk;
    logic [31:0] d;
    rstn_i = 1'b0;
    ch.ch_valid_i = 1'b0;
    ch.ch_data_i = '0;
    ch.en_i = 1'b1;
    ch.a_ack_i = 1'b0;
    m_init = 1'b0;
    m_acc = '0;
    repeat (2) @(negedge clk);
    check_all();
    rstn_i = 1'b1;
    step(0, 0, 1, 0);
    chk("ready_after_init", 32'(ch.ch_ready_o), 32'd1);
    step(1, 32'h00C0_0000, 1, 0);
    chk("single_data", ch.a_data_o, 32'h00C0_0000);
    chk("single_margin", 32'(ch.ch_margin_o), 32'd31);
    step(0, 0, 1, 1);
    for (int i = 0; i < 34; i++) step(1, 32'h00C1_0000 + 32'(i), 1, 0);
    chk("full_margin", 32'(ch.ch_margin_o), 32'd0);
    chk("full_ready", 32'(ch.ch_ready_o), 32'd0);
    chk("full_acc", 32'(ch.acc_cnt_o), 32'd33);
    step(1, 32'h00C1_0020, 1, 1);
    chk("pop_full_margin", 32'(ch.ch_margin_o), 32'd1);
    chk("pop_full_ready", 32'(ch.ch_ready_o), 32'd1);
    step(1, 32'h00C1_0020, 1, 0);
    for (int i = 0; i < 40 && q.size() != 0; i++) step(0, 0, 1, 1);
    chk("drained", 32'(ch.a_req_o), 32'd0);
    for (int i = 0; i < 100; i++) step(1, 32'h00C2_0000 + 32'(i), 1, 1);
    chk("stream_margin", 32'(ch.ch_margin_o), 32'd31);
    step(0, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(1, 32'h00C3_0000 + 32'(i), 1, 0);
    for (int i = 0; i < 5; i++) step(1, 32'h00C4_0000 + 32'(i), 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 32'h00C5_0000 + 32'(i), 1, 0);
    pulse_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) begin
        pv = $urandom_range(10, 95);
        pk = $urandom_range(5, 90);
      end
      if ($urandom_range(0, 399) == 0) pulse_reset();
      d = $urandom;
      step($urandom_range(0, 99) < pv, d, $urandom_range(0, 7) != 0, $urandom_range(0, 99) < pk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
